// File: rtl/s_divider_pkg.sv
// Shared definitions for the RSA arithmetic units (s_divider, S_multi).
// Holds the default operand width and the 1-bit IDLE/RUN state encoding
// so both units present the same start/busy control behaviour.
package s_divider_pkg;

  localparam int SDIV_BIT_DEF = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/s_div_step.sv
// Purpose : one restoring shift-subtract iteration (combinational).
// Latency : 0 cycles, pure combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports   : p (partial remainder), msb (next dividend bit), divisor ->
//           p_nxt (next partial remainder), q_bit (quotient bit).
module s_div_step
  import s_divider_pkg::*;
#(
  parameter int BIT = SDIV_BIT_DEF
) (
  input  logic [BIT-1:0] p,
  input  logic           msb,
  input  logic [BIT-1:0] divisor,
  output logic [BIT-1:0] p_nxt,
  output logic           q_bit
);

  logic [BIT:0] s;
  logic [BIT:0] t;

  // The partial remainder is always below the divisor, so its top bit of
  // the BIT+1 wide form is always zero and only BIT bits are carried.
  // The trial subtract is BIT+1 wide so t[BIT] is the borrow.
  always_comb begin
    s = {p, msb};
    t = s - {1'b0, divisor};
    if (!t[BIT]) begin
      p_nxt = t[BIT-1:0];
      q_bit = 1'b1;
    end else begin
      p_nxt = s[BIT-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/s_divider.sv
// Purpose : sequential restoring divider, Q = A / B, R = A % B (unsigned).
// Latency : busy high for BIT cycles after the accepting edge; done pulses as busy falls.
// Backpressure: start is only sampled while idle; start during busy is ignored.
// Ports   : clk, rst_n (async active-low), start, A, B -> busy, done, Q, R.
// Option  : define SDIV_DBZ_FLAG_EN to add the dbz (divide-by-zero) output,
//           registered with the operands and held until the next accepted start.
module s_divider
  import s_divider_pkg::*;
#(
  parameter int BIT = SDIV_BIT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic [BIT-1:0] A,
  input  logic [BIT-1:0] B,
  output logic [BIT-1:0] Q,
  output logic [BIT-1:0] R
`ifdef SDIV_DBZ_FLAG_EN
  ,
  output logic           dbz
`endif
);

  localparam int CW = $clog2(BIT + 1);

  logic [0:0]     state;
  logic [CW-1:0]  count;
  logic [BIT-1:0] dvd;   // dividend shift register, MSB consumed first
  logic [BIT-1:0] dvs;   // captured divisor
  logic [BIT-1:0] p;     // partial remainder
  logic [BIT-1:0] qs;    // quotient under construction, kept off Q until done

  logic [BIT-1:0] p_nxt;
  logic           q_bit;

  s_div_step #(.BIT(BIT)) u_step (
    .p      (p),
    .msb    (dvd[BIT-1]),
    .divisor(dvs),
    .p_nxt  (p_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      dvd   <= '0;
      dvs   <= '0;
      p     <= '0;
      qs    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Q     <= '0;
      R     <= '0;
`ifdef SDIV_DBZ_FLAG_EN
      dbz   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          dvd   <= A;
          dvs   <= B;
          p     <= '0;
          qs    <= '0;
          count <= CW'(BIT);
          busy  <= 1'b1;
          state <= ST_RUN;
`ifdef SDIV_DBZ_FLAG_EN
          dbz   <= (B == '0);
`endif
        end
      end else begin
        p     <= p_nxt;
        qs    <= {qs[BIT-2:0], q_bit};
        dvd   <= dvd << 1;
        count <= count - 1'b1;
        // Last iteration: publish the result from the step outputs directly
        // so Q/R appear on the same edge busy falls.
        if (count == CW'(1)) begin
          Q     <= {qs[BIT-2:0], q_bit};
          R     <= p_nxt;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_s_divider.sv
module tb_s_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
`ifdef SDIV_DBZ_FLAG_EN
  logic       dbz;
`endif

  s_divider #(.BIT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .busy (busy),
    .done (done),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R)
`ifdef SDIV_DBZ_FLAG_EN
    ,
    .dbz  (dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_miss = 0;

  // ---------------- monitor / scoreboard ----------------
  int         bcnt = 0;
  logic       prev_done = 1'b0;
  logic [7:0] held_q = 8'h00;
  logic [7:0] held_r = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt      = 0;
      prev_done = 1'b0;
      held_q    = 8'h00;
      held_r    = 8'h00;
    end else begin
      if (busy) begin
        bcnt++;
        n_cmp++;
        if (Q !== held_q || R !== held_r) begin
          n_miss++;
          $display("FAIL hold_during_run Q=%h R=%h required Q=%h R=%h", Q, R, held_q, held_r);
        end
      end
      if (done) begin
        exp_t e;
        n_cmp++;
        if (prev_done) begin
          n_miss++;
          $display("FAIL done_width done high two cycles, required one");
        end
        n_cmp++;
        if (bcnt != 8) begin
          n_miss++;
          $display("FAIL busy_width got %0d cycles required 8", bcnt);
        end
        bcnt = 0;
        n_cmp++;
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_done Q=%h R=%h required no result", Q, R);
        end else begin
          e = sb.pop_front();
          if (Q !== e.q || R !== e.r) begin
            n_miss++;
            $display("FAIL result %h/%h Q=%h R=%h required Q=%h R=%h", e.a, e.b, Q, R, e.q, e.r);
          end
`ifdef SDIV_DBZ_FLAG_EN
          n_cmp++;
          if (dbz !== e.z) begin
            n_miss++;
            $display("FAIL dbz %h/%h got %b required %b", e.a, e.b, dbz, e.z);
          end
`endif
          held_q = e.q;
          held_r = e.r;
        end
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input bit push);
    exp_t e;
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < 40) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (busy) begin
      n_miss++;
      $display("FAIL idle_wait busy=%b required 0", busy);
    end
    A = a;
    B = b;
    start = 1'b1;
    if (push) begin
      e.a = a; e.b = b; e.q = eq; e.r = er; e.z = (b == 8'h00);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_miss++;
      $display("FAIL accept %h/%h busy=%b required 1", a, b, busy);
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < 40);
    n_cmp++;
    if (!done) begin
      n_miss++;
      $display("FAIL done_timeout done=%b required 1", done);
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er);
    issue(a, b, eq, er, 1'b1);
    wait_done();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b required 0", busy); end
    if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done got %b required 0", done); end
    if (Q !== 8'h00)   begin n_miss++; $display("FAIL reset_Q got %h required 00", Q); end
    if (R !== 8'h00)   begin n_miss++; $display("FAIL reset_R got %h required 00", R); end
`ifdef SDIV_DBZ_FLAG_EN
    n_cmp++;
    if (dbz !== 1'b0)  begin n_miss++; $display("FAIL reset_dbz got %b required 0", dbz); end
`endif
    rst_n = 1'b1;

    run(8'h11, 8'h02, 8'h08, 8'h01);
    run(8'hFF, 8'h01, 8'hFF, 8'h00);
    run(8'h05, 8'h09, 8'h00, 8'h05);
    run(8'h00, 8'h07, 8'h00, 8'h00);
    run(8'h37, 8'h00, 8'hFF, 8'h37);
    run(8'h37, 8'h05, 8'h0B, 8'h00);

    // start pulse mid-run must be ignored
    issue(8'hC8, 8'h0A, 8'h14, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    A = 8'h01;
    B = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL ignored_start busy=%b required 0", busy);
    end

    // asynchronous reset mid-division
    issue(8'hC8, 8'h0A, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL abort_busy got %b required 0", busy); end
    if (done !== 1'b0) begin n_miss++; $display("FAIL abort_done got %b required 0", done); end
    if (Q !== 8'h00)   begin n_miss++; $display("FAIL abort_Q got %h required 00", Q); end
    if (R !== 8'h00)   begin n_miss++; $display("FAIL abort_R got %h required 00", R); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h64, 8'h07, 8'h0E, 8'h02);

    // start held high across three operand pairs
    begin
      logic [7:0] pa [3];
      logic [7:0] pb [3];
      logic [7:0] pq [3];
      logic [7:0] pr [3];
      exp_t e;
      int n;
      pa[0] = 8'h37; pb[0] = 8'h05; pq[0] = 8'h0B; pr[0] = 8'h00;
      pa[1] = 8'hFA; pb[1] = 8'h07; pq[1] = 8'h23; pr[1] = 8'h05;
      pa[2] = 8'h80; pb[2] = 8'h03; pq[2] = 8'h2A; pr[2] = 8'h02;
      @(negedge clk);
      A = pa[0]; B = pb[0]; start = 1'b1;
      e.a = pa[0]; e.b = pb[0]; e.q = pq[0]; e.r = pr[0]; e.z = 1'b0;
      sb.push_back(e);
      for (int k = 0; k < 3; k++) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!done && n < 30);
        n_cmp++;
        if (!done) begin
          n_miss++;
          $display("FAIL b2b_timeout pair %0d done=%b required 1", k, done);
        end
        if (k > 0) begin
          n_cmp++;
          if (n != 9) begin
            n_miss++;
            $display("FAIL b2b_spacing pair %0d got %0d cycles required 9", k, n);
          end
        end
        if (k < 2) begin
          A = pa[k+1]; B = pb[k+1];
          e.a = pa[k+1]; e.b = pb[k+1]; e.q = pq[k+1]; e.r = pr[k+1]; e.z = 1'b0;
          sb.push_back(e);
        end else begin
          start = 1'b0;
        end
      end
    end

    // reference model over random operands
    for (int v = 0; v < 1000; v++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run(ra, rb, ra / rb, ra % rb);
    end

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain %0d results outstanding required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
